// File: rtl/uart_axil_bridge.sv
// AXI4-Lite master that polls an axi_uartlite slave and buffers both byte streams.
// Define UART_BRIDGE_ERR_STAT_EN to add the err_stat overrun/frame/parity counters.
module uart_axil_bridge #(
    parameter int unsigned TX_DEPTH  = 16,
    parameter int unsigned RX_DEPTH  = 16,
    parameter int unsigned POLL_GAP  = 8,
    parameter logic [3:0]  BASE_ADDR = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  tx_tdata,
    input  logic        tx_tvalid,
    output logic        tx_tready,
    output logic [7:0]  rx_tdata,
    output logic        rx_tvalid,
    input  logic        rx_tready,
    output logic [3:0]  m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [3:0]  m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
`ifdef UART_BRIDGE_ERR_STAT_EN
    output logic [23:0] err_stat,
`endif
    output logic        busy,
    output logic        axi_err
);

    localparam int unsigned TAW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RAW = $clog2(RX_DEPTH) + 1;
    localparam logic [3:0] ADDR_RX   = BASE_ADDR + 4'h0;
    localparam logic [3:0] ADDR_TX   = BASE_ADDR + 4'h4;
    localparam logic [3:0] ADDR_STAT = BASE_ADDR + 4'h8;
    localparam logic [3:0] ADDR_CTRL = BASE_ADDR + 4'hC;
    localparam logic [15:0] GAP_M1   = 16'(POLL_GAP - 1);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_STAT_R, S_RX_RD, S_TX_WR, S_WAIT
    } state_t;

    state_t      state_q;
    logic        issued_q;
    logic [15:0] wait_q;
    logic        awvalid_q, wvalid_q, bready_q;
    logic        arvalid_q, rready_q;
    logic [3:0]  awaddr_q, araddr_q;
    logic [31:0] wdata_q;
    logic        busy_q, err_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign aw_hs = awvalid_q && m_axi_awready;
    assign w_hs  = wvalid_q && m_axi_wready;
    assign b_hs  = bready_q && m_axi_bvalid;
    assign ar_hs = arvalid_q && m_axi_arready;
    assign r_hs  = rready_q && m_axi_rvalid;

    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wp_q, tx_rp_q;
    logic           tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]     tx_head;

    assign tx_empty  = tx_wp_q == tx_rp_q;
    assign tx_full   = (tx_wp_q[TAW-1] != tx_rp_q[TAW-1]) &&
                       (tx_wp_q[TAW-2:0] == tx_rp_q[TAW-2:0]);
    assign tx_pop    = (state_q == S_TX_WR) && b_hs;
    assign tx_tready = !tx_full || tx_pop;
    assign tx_push   = tx_tvalid && tx_tready;
    assign tx_head   = tx_mem[tx_rp_q[TAW-2:0]];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TAW-2:0]] <= tx_tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
        end else begin
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
        end
    end

    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wp_q, rx_rp_q;
    logic           rx_full, rx_push, rx_pop;

    assign rx_full   = (rx_wp_q[RAW-1] != rx_rp_q[RAW-1]) &&
                       (rx_wp_q[RAW-2:0] == rx_rp_q[RAW-2:0]);
    assign rx_push   = (state_q == S_RX_RD) && r_hs;
    assign rx_tvalid = rx_wp_q != rx_rp_q;
    assign rx_pop    = rx_tvalid && rx_tready;
    assign rx_tdata  = rx_mem[rx_rp_q[RAW-2:0]];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp_q[RAW-2:0]] <= m_axi_rdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
        end
    end

    // Channel handshakes are retired first; the state case may then start the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            issued_q  <= 1'b0;
            wait_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if (ar_hs) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (r_hs) begin
                rready_q <= 1'b0;
                if (m_axi_rresp != 2'b00) err_q <= 1'b1;
            end
            if (b_hs) begin
                bready_q <= 1'b0;
                if (m_axi_bresp != 2'b00) err_q <= 1'b1;
            end
            unique case (state_q)
                S_INIT: begin
                    if (!issued_q) begin
                        issued_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        awaddr_q  <= ADDR_CTRL;
                        wdata_q   <= 32'h3;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        bready_q  <= 1'b1;
                    end else if (b_hs) begin
                        issued_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    araddr_q  <= ADDR_STAT;
                    arvalid_q <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= S_STAT_R;
                end
                S_STAT_R: begin
                    if (r_hs) begin
                        if (m_axi_rdata[0] && !rx_full) begin
                            araddr_q  <= ADDR_RX;
                            arvalid_q <= 1'b1;
                            state_q   <= S_RX_RD;
                        end else if (!m_axi_rdata[3] && !tx_empty) begin
                            awaddr_q  <= ADDR_TX;
                            wdata_q   <= {24'h0, tx_head};
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            bready_q  <= 1'b1;
                            state_q   <= S_TX_WR;
                        end else begin
                            wait_q  <= GAP_M1;
                            busy_q  <= 1'b0;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_RX_RD: begin
                    if (r_hs) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_TX_WR: begin
                    if (b_hs) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (wait_q == 16'd0) state_q <= S_IDLE;
                    else wait_q <= wait_q - 16'd1;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

`ifdef UART_BRIDGE_ERR_STAT_EN
    logic [7:0] ovr_q, frm_q, par_q;
    logic       stat_hs;

    assign stat_hs  = (state_q == S_STAT_R) && r_hs;
    assign err_stat = {par_q, frm_q, ovr_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
            frm_q <= '0;
            par_q <= '0;
        end else if (stat_hs) begin
            if (m_axi_rdata[5] && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
            if (m_axi_rdata[6] && frm_q != 8'hFF) frm_q <= frm_q + 8'd1;
            if (m_axi_rdata[7] && par_q != 8'hFF) par_q <= par_q + 8'd1;
        end
    end
`endif

    logic unused_rdata;
    assign unused_rdata = ^{m_axi_rdata[31:8], m_axi_rdata[7:4],
                            m_axi_rdata[2:1]};

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign busy          = busy_q;
    assign axi_err       = err_q;

endmodule

// File: doc/uart_axil_bridge.md
Name: uart_axil_bridge

Overview:
- AXI4-Lite master that drives an axi_uartlite-compatible slave and exposes byte streams to the fabric.
- Polls STAT, drains the RX FIFO into a local RX buffer, and feeds bytes from a local TX buffer into the TX FIFO.
- Sits between the UART IP instance and the command/loader logic, so no other logic ever touches UART AXI signals.
- Successor to the raw UART instance wiring: adds parametrised buffering, a poll timer and error capture.

Parameters:
- TX_DEPTH, 16, local TX buffer entries, power of 2, 2..256.
- RX_DEPTH, 16, local RX buffer entries, power of 2, 2..256.
- POLL_GAP, 8, idle cycles between STAT polls when there is no work, 1..65535.
- BASE_ADDR, 4'h0, UART register base; registers sit at BASE_ADDR + 0x0 RX, +0x4 TX, +0x8 STAT, +0xC CTRL.

Ports:
- clk  in  1  single clock for the fabric and the AXI side.
- rst_n  in  1  reset, asynchronous assert, active-low.
- tx_tdata  in  8  byte to transmit.
- tx_tvalid  in  1  tx_tdata is valid.
- tx_tready  out  1  TX buffer not full.
- rx_tdata  out  8  received byte.
- rx_tvalid  out  1  rx_tdata is valid.
- rx_tready  in  1  consumer accepts the byte.
- m_axi_awaddr  out  4  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  write strobe.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  4  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- busy  out  1  FSM not in IDLE or WAIT.
- axi_err  out  1  sticky; set on any bresp or rresp != 2'b00; cleared only by reset.

Behaviour:
- Reset: all valid/ready outputs, busy and axi_err go to 0; buffers are emptied; FSM enters INIT.
- At most one AXI transaction is outstanding at any time.
- Write transactions: AW and W are asserted in the same cycle. Each channel deasserts independently on its own handshake. bready stays high until bvalid is seen.
- Read transactions: rready is asserted from the AR handshake until the R handshake.
- wstrb is always 4'hF. Upper wdata bits are 0.
- FSM states:
  - INIT: write CTRL=0x3 to reset the UART FIFOs, then go to IDLE.
  - IDLE: issue an AR to STAT; go to STAT_R.
  - STAT_R: on the R handshake, latch rdata[7:0].
  - Decision after STAT_R, in this order:
    1. RX: if stat[0] (RX valid) and the RX buffer is not full, read RX.
    2. TX: else if !stat[3] (TX not full) and the TX buffer is not empty, write TX.
    3. WAIT: otherwise wait POLL_GAP cycles, then return to IDLE.
  - RX_RD: rdata[7:0] is pushed into the RX buffer on the R handshake; then go to IDLE.
  - TX_WR: the TX buffer head is popped on the B handshake, not before; then go to IDLE.
- RX priority over TX prevents UART RX overrun. After any RX or TX transaction the next poll starts with no WAIT.
- Error responses:
  - RX read with error: the data is still pushed; axi_err is set.
  - TX write with error: the byte is still popped; axi_err is set.
- Stream side:
  - Push and pop in the same cycle on a full or empty buffer are legal.
  - tx_tready deasserts only when the buffer is full, counting the same-cycle pop.
  - rx_tvalid/rx_tdata come from the RX buffer head. Latency is 1 cycle after the R handshake.
  - rx_tdata stays stable while rx_tvalid=1 and rx_tready=0.
- Buffer pointers are log2(DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the rest are equal.
- rst_n asserted mid-transaction: all AXI valids drop asynchronously, the in-flight byte is lost, and INIT re-runs.
- The WAIT counter is 16 bits; it reloads to POLL_GAP-1 on entry and exits at 0.

Optional Feature:
- Macro: UART_BRIDGE_ERR_STAT_EN.
- When defined:
  - Adds output err_stat[23:0], made of three 8-bit saturating counters: [7:0] overrun (stat[5]), [15:8] frame (stat[6]), [23:16] parity (stat[7]).
  - Each counter increments once per STAT_R handshake where its bit is 1. It saturates at 255 and resets to 0.
- When not defined: the port and the counters do not exist; status bits 5..7 are ignored.

Test Plan:
- Reset release: first AXI op is a write of 0x3 to addr 0xC, then a read of addr 0x8; no stream valids are asserted.
- Slave stat=0x01 with RX fifo holding 0x41, 0x42, rx_tready=1: RX reads at addr 0x0; rx_tdata is 0x41 then 0x42; no WAIT between the reads.
- Push 0x10..0x1F (16 bytes) with stat=0x04: tx_tready falls after the 16th byte; 16 writes to addr 0x4 occur in order; tx_tready rises after the first B.
- stat=0x09 (RX valid and TX full) with TX buffer non-empty: only RX reads occur until stat[3]=0.
- rx_tready=0 with RX_DEPTH=4 and stat bit 0 always 1: exactly 4 RX reads, then STAT polls spaced POLL_GAP=8 cycles.
- bresp=2'b10 on a TX write: axi_err=1 and stays set; the byte is popped; the next transfer proceeds normally. With UART_BRIDGE_ERR_STAT_EN, stat=0x20 for 3 polls gives err_stat[7:0]=3.
